fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 82 ++++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, one in-flight fetch against a 1-cycle memory,
// and a 2-entry {instr, pc} buffer feeding decode, with branch redirect.
module fetch_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_from_inst_memory,
  output logic [ADDR_W-1:0] address_to_inst_mem,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic [DATA_W-1:0] r_instr [2];
  logic [ADDR_W-1:0] r_ipc   [2];
  logic              r_head;
  logic [1:0]        r_count;

  logic       w_pop;
  logic       w_push;
  logic [2:0] w_occ;
  logic       w_issue;
  logic       w_tail;

  assign w_pop   = (r_count != 2'd0) && !stall && !branch_taken;
  assign w_push  = r_inflight && !branch_taken;
  // Slots committed after this edge: buffered entries left plus the returning fetch.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = !branch_taken && (w_occ < 3'd2);
  // Free slot is head+count modulo 2; with count=2 it aliases the slot being popped.
  assign w_tail  = r_head ^ r_count[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_head        <= 1'b0;
      r_count       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_instr[i] <= '0;
        r_ipc[i]   <= '0;
      end
    end else if (branch_taken) begin
      r_pc       <= branch_target;
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (w_push) begin
        r_instr[w_tail] <= data_from_inst_memory;
        r_ipc[w_tail]   <= r_inflight_pc;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_count    <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + ADDR_W'(1);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == 2'd2) && !w_pop));

  assign address_to_inst_mem = r_pc;
  assign instr_out           = r_instr[r_head];
  assign pc_out              = r_ipc[r_head];
  assign instr_valid         = (r_count != 2'd0);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/branch traffic,
// checked against a queue-based transaction model of the fetch buffer.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [15:0] mem_data;
  logic [4:0]  address_to_inst_mem;
  logic        stall;
  logic        branch_taken;
  logic [4:0]  branch_target;
  logic [15:0] instr_out;
  logic [4:0]  pc_out;
  logic        instr_valid;

  int n_checks = 0;
  int n_err    = 0;

  logic [20:0] m_q[$];
  logic        m_infl;
  logic [4:0]  m_ipc;
  logic [4:0]  m_pc;

  logic [4:0] wrap_exp [5] = '{5'd29, 5'd30, 5'd31, 5'd0, 5'd1};

  fetch_stage dut (
    .clk                   (clk),
    .rst                   (rst),
    .data_from_inst_memory (mem_data),
    .address_to_inst_mem   (address_to_inst_mem),
    .stall                 (stall),
    .branch_taken          (branch_taken),
    .branch_target         (branch_target),
    .instr_out             (instr_out),
    .pc_out                (pc_out),
    .instr_valid           (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns the word for last cycle's address.
  always @(posedge clk) mem_data <= 16'hA000 | {11'd0, address_to_inst_mem};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_infl = 1'b0;
    m_ipc  = 5'd0;
    m_pc   = 5'd0;
  endtask

  task automatic model_edge(input logic s, input logic b, input logic [4:0] t);
    int occ;
    bit pop;
    if (b) begin
      m_q.delete();
      m_infl = 1'b0;
      m_pc   = t;
    end else begin
      pop = (m_q.size() > 0) && !s;
      occ = m_q.size() - int'(pop) + int'(m_infl);
      if (pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back({16'hA000 | {11'd0, m_ipc}, m_ipc});
      if (occ < 2) begin
        m_ipc  = m_pc;
        m_pc   = 5'((int'(m_pc) + 1) % 32);
        m_infl = 1'b1;
      end else begin
        m_infl = 1'b0;
      end
    end
  endtask

  task automatic chk_model();
    chk("m_addr", address_to_inst_mem, m_pc);
    chk("m_valid", instr_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("m_instr", instr_out, m_q[0][20:5]);
      chk("m_pc", pc_out, m_q[0][4:0]);
    end
  endtask

  task automatic step(input logic s, input logic b, input logic [4:0] t);
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    model_edge(s, b, t);
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    chk_model();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_addr", address_to_inst_mem, 5'd0);
    chk("rst_instr", instr_out, 16'h0);
    chk("rst_pc", pc_out, 5'd0);
    rst = 1'b0;
    model_reset();

    // Start-up: fetch 0 issues on the first edge, visible after the second.
    step(0, 0, 0);
    chk("boot_valid_early", instr_valid, 1'b0);
    chk("boot_addr", address_to_inst_mem, 5'd1);
    step(0, 0, 0);
    chk("boot_valid", instr_valid, 1'b1);
    chk("boot_instr", instr_out, 16'hA000);
    chk("boot_pc", pc_out, 5'd0);
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0);
      chk("boot_seq_pc", pc_out, 5'(k));
    end

    // Stall with pc 3 at head.
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0);
      chk("stall_instr", instr_out, 16'hA003);
      chk("stall_addr", address_to_inst_mem, 5'd5);
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0);
      chk("unstall_pc", pc_out, 5'(4 + k));
    end

    // Redirect while buffer full.
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 5'd20);
    chk("br_gap0", instr_valid, 1'b0);
    step(0, 0, 0);
    chk("br_gap1", instr_valid, 1'b0);
    step(0, 0, 0);
    chk("br_valid", instr_valid, 1'b1);
    chk("br_pc", pc_out, 5'd20);
    chk("br_instr", instr_out, 16'hA014);

    // Address wrap.
    step(0, 1, 5'd28);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("wrap_pc28", pc_out, 5'd28);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0);
      chk("wrap_pc", pc_out, wrap_exp[k]);
      chk("wrap_instr", instr_out, 16'hA000 | {11'd0, wrap_exp[k]});
    end

    // Redirect together with stall.
    step(1, 1, 5'd9);
    chk("brst_gap", instr_valid, 1'b0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("brst_pc", pc_out, 5'd9);
    chk("brst_instr", instr_out, 16'hA009);

    // Asynchronous reset between edges.
    step(0, 0, 0);
    chk("arst_pre_valid", instr_valid, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", instr_valid, 1'b0);
    chk("arst_addr", address_to_inst_mem, 5'd0);
    chk("arst_instr", instr_out, 16'h0);
    chk("arst_pc", pc_out, 5'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(0, 0, 0);
    chk("arst_gap", instr_valid, 1'b0);
    step(0, 0, 0);
    chk("arst_restart_pc", pc_out, 5'd0);
    chk("arst_restart_instr", instr_out, 16'hA000);

    // Random stall/redirect traffic.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, 5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
